multicycle_control: RTL and testbench

Moore-style control FSM for the multicycle ARM datapath, directly upstream of the immediate extender. It decodes the instruction register fields, drives ImmSrc (01 data-processing, 10 LDR/STR, 11 branch, 00 none) and every datapath mux and enable. It also holds the NZCV condition flags and gates all architectural writes on the condition check.

---
 rtl/multicycle_control.sv | 166 ++++++++++++++++
 tb/tb_multicycle_control.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle ARM datapath, with NZCV flag register and condition gating.
// Latency: DP 4, LDR 5, STR 4, B 3, undefined 2 cycles. No backpressure. Optional macro: CMP_NOWRITE_EN.
module multicycle_control (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic [1:0] RegSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic [1:0] ALUControl
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BRANCH
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] flags;
   logic       nextpc, regw, memw, branch, aluop, irw;
   logic [1:0] alu_ctl;
   logic       flag_wr, cv_wr, nowrite, condex, pcs;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= FETCH;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = FETCH;
      nextpc    = 1'b0;
      regw      = 1'b0;
      memw      = 1'b0;
      branch    = 1'b0;
      aluop     = 1'b0;
      irw       = 1'b0;
      AdrSrc    = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      case (state)
         FETCH: begin
            state_nxt = DECODE;
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            irw       = 1'b1;
            nextpc    = 1'b1;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            case (Op)
               2'b01:   state_nxt = MEMADR;
               2'b00:   state_nxt = Funct[5] ? EXECUTEI : EXECUTER;
               2'b10:   state_nxt = BRANCH;
               default: state_nxt = FETCH;
            endcase
         end
         MEMADR: begin
            state_nxt = Funct[0] ? MEMREAD : MEMWRITE;
            ALUSrcB   = 2'b01;
         end
         MEMREAD: begin
            state_nxt = MEMWB;
            AdrSrc    = 1'b1;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            regw      = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc = 1'b1;
            memw   = 1'b1;
         end
         EXECUTER: begin
            state_nxt = ALUWB;
            aluop     = 1'b1;
         end
         EXECUTEI: begin
            state_nxt = ALUWB;
            ALUSrcB   = 2'b01;
            aluop     = 1'b1;
         end
         ALUWB: regw = 1'b1;
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            branch    = 1'b1;
         end
         default: state_nxt = FETCH;
      endcase
   end

   // cmd decode: flag_wr marks the recognised ops; cv_wr the arithmetic ones that own C,V
   always_comb begin
      alu_ctl = 2'b00;
      flag_wr = 1'b0;
      cv_wr   = 1'b0;
      nowrite = 1'b0;
      case (Funct[4:1])
         4'b0100: begin alu_ctl = 2'b00; flag_wr = 1'b1; cv_wr = 1'b1; end
         4'b0010: begin alu_ctl = 2'b01; flag_wr = 1'b1; cv_wr = 1'b1; end
         4'b0000: begin alu_ctl = 2'b10; flag_wr = 1'b1; end
         4'b1100: begin alu_ctl = 2'b11; flag_wr = 1'b1; end
`ifdef CMP_NOWRITE_EN
         4'b1010: begin alu_ctl = 2'b01; flag_wr = 1'b1; cv_wr = 1'b1; nowrite = 1'b1; end
`endif
         default: alu_ctl = 2'b00;
      endcase
   end

   always_comb begin
      condex = 1'b0;
      case (Cond)
         4'b0000: condex = flags[2];
         4'b0001: condex = ~flags[2];
         4'b0010: condex = flags[1];
         4'b0011: condex = ~flags[1];
         4'b0100: condex = flags[3];
         4'b0101: condex = ~flags[3];
         4'b0110: condex = flags[0];
         4'b0111: condex = ~flags[0];
         4'b1000: condex = flags[1] & ~flags[2];
         4'b1001: condex = ~(flags[1] & ~flags[2]);
         4'b1010: condex = (flags[3] == flags[0]);
         4'b1011: condex = (flags[3] != flags[0]);
         4'b1100: condex = ~flags[2] & (flags[3] == flags[0]);
         4'b1101: condex = ~(~flags[2] & (flags[3] == flags[0]));
         4'b1110: condex = 1'b1;
         default: condex = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags <= 4'b0000;
      end else if ((state == EXECUTER || state == EXECUTEI) && Funct[0] && condex && flag_wr) begin
         flags[3:2] <= ALUFlags[3:2];
         if (cv_wr) flags[1:0] <= ALUFlags[1:0];
      end
   end

   assign pcs        = (regw & (Rd == 4'b1111)) | branch;
   // enables are masked directly by reset so nothing writes while reset_n is low
   assign PCWrite    = reset_n & (nextpc | (pcs & condex));
   assign RegWrite   = reset_n & regw & condex & ~nowrite;
   assign MemWrite   = reset_n & memw & condex;
   assign IRWrite    = reset_n & irw;
   assign ALUControl = aluop ? alu_ctl : 2'b00;
   assign ImmSrc     = (Op == 2'b11) ? 2'b00 : Op + 2'b01;
   assign RegSrc     = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised and directed bench for multicycle_control against an instruction-level reference model.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [3:0] Cond = 4'he;
   logic [1:0] Op = 2'b11;
   logic [5:0] Funct = 6'd0;
   logic [3:0] Rd = 4'd0;
   logic [3:0] ALUFlags = 4'd0;
   logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
   logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

   int vectors = 0;
   int miscompares = 0;
   logic [3:0] mflags = 4'd0;

   multicycle_control dut (
      .clk(clk), .reset_n(reset_n), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
      .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
   );

   always #5 clk = ~clk;

   logic [15:0] obs;
   assign obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
                 ALUSrcB, ResultSrc, ImmSrc, ALUControl};

   // Architectural condition rule: pairs of conditions share a base test, odd code inverts it
   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hf) return 1'b0;
      if (c == 4'he) return 1'b1;
      return base ^ c[0];
   endfunction

   function automatic logic is_cmp(input logic [5:0] fn);
`ifdef CMP_NOWRITE_EN
      return fn[4:1] == 4'b1010;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [1:0] op_sel(input logic [5:0] fn);
      if (is_cmp(fn)) return 2'b01;
      case (fn[4:1])
         4'b0100: return 2'b00;
         4'b0010: return 2'b01;
         4'b0000: return 2'b10;
         4'b1100: return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic known_op(input logic [5:0] fn);
      return is_cmp(fn) || fn[4:1] inside {4'b0100, 4'b0010, 4'b0000, 4'b1100};
   endfunction

   function automatic logic arith_op(input logic [5:0] fn);
      return is_cmp(fn) || fn[4:1] inside {4'b0100, 4'b0010};
   endfunction

   function automatic logic [15:0] vec(input logic pcw, input logic mw, input logic rw,
                                       input logic irw, input logic adr, input logic [1:0] rsrc,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] rs, input logic [1:0] imm,
                                       input logic [1:0] alc);
      return {pcw, mw, rw, irw, adr, rsrc, asa, asb, rs, imm, alc};
   endfunction

   task automatic step(input logic [15:0] exp, input string nm);
      @(negedge clk);
      vectors++;
      if (obs !== exp) begin
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, obs, exp, $time);
         miscompares++;
      end
      @(posedge clk);
      #1;
   endtask

   // Plays one instruction for up to ncyc cycles, building the expected cycle sequence first
   task automatic run_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                            input logic [3:0] rd, input logic [3:0] af, input int ncyc,
                            input string nm);
      logic [15:0] q[$];
      string       qn[$];
      logic [1:0]  imm, rsrc;
      logic        ce;
      Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
      imm  = (op == 2'b11) ? 2'b00 : op + 2'b01;
      rsrc = {op == 2'b01, op == 2'b10};
      q.push_back(vec(1,0,0,1,0,rsrc,1,2'b10,2'b10,imm,2'b00)); qn.push_back({nm, ".fetch"});
      q.push_back(vec(0,0,0,0,0,rsrc,1,2'b10,2'b10,imm,2'b00)); qn.push_back({nm, ".decode"});
      ce = cond_ok(c, mflags);
      case (op)
         2'b01: begin
            q.push_back(vec(0,0,0,0,0,rsrc,0,2'b01,2'b00,imm,2'b00)); qn.push_back({nm, ".memadr"});
            if (fn[0]) begin
               q.push_back(vec(0,0,0,0,1,rsrc,0,2'b00,2'b00,imm,2'b00)); qn.push_back({nm, ".memread"});
               q.push_back(vec(ce && rd == 4'hf,0,ce,0,0,rsrc,0,2'b00,2'b01,imm,2'b00));
               qn.push_back({nm, ".memwb"});
            end else begin
               q.push_back(vec(0,ce,0,0,1,rsrc,0,2'b00,2'b00,imm,2'b00)); qn.push_back({nm, ".memwrite"});
            end
         end
         2'b00: begin
            q.push_back(vec(0,0,0,0,0,rsrc,0,fn[5] ? 2'b01 : 2'b00,2'b00,imm,op_sel(fn)));
            qn.push_back({nm, ".execute"});
            if (fn[0] && ce && known_op(fn)) begin
               mflags[3:2] = af[3:2];
               if (arith_op(fn)) mflags[1:0] = af[1:0];
            end
            ce = cond_ok(c, mflags);
            q.push_back(vec(ce && rd == 4'hf,0,ce && !is_cmp(fn),0,0,rsrc,0,2'b00,2'b00,imm,2'b00));
            qn.push_back({nm, ".aluwb"});
         end
         2'b10: begin
            q.push_back(vec(ce,0,0,0,0,rsrc,0,2'b01,2'b10,imm,2'b00)); qn.push_back({nm, ".branch"});
         end
         default: ;
      endcase
      for (int i = 0; i < q.size() && i < ncyc; i++) step(q[i], qn[i]);
   endtask

   task automatic test_reset;
      logic [15:0] rv;
      #1 reset_n = 1'b0;
      Cond = 4'he; Op = 2'b01; Funct = 6'b011001; Rd = 4'd2;
      rv = vec(0,0,0,0,0,2'b10,1,2'b10,2'b10,2'b10,2'b00);
      @(posedge clk); #1;
      step(rv, "reset.por");
      reset_n = 1'b1;
      mflags = 4'd0;
      run_instr(4'he, 2'b00, 6'b000101, 4'd1, 4'b0111, 99, "reset.subs");
      run_instr(4'he, 2'b01, 6'b011001, 4'd2, 4'd0, 3, "reset.ldr");
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) step(rv, "reset.midread");
      reset_n = 1'b1;
      mflags = 4'd0;
      run_instr(4'h0, 2'b10, 6'd0, 4'd0, 4'd0, 99, "reset.beq_flags_clear");
      run_instr(4'h2, 2'b10, 6'd0, 4'd0, 4'd0, 99, "reset.bcs_flags_clear");
   endtask

   task automatic test_dp;
      run_instr(4'he, 2'b00, 6'b001000, 4'd1, 4'd0, 99, "dp.add");
      run_instr(4'he, 2'b00, 6'b100001, 4'd3, 4'b1000, 99, "dp.andsi");
      run_instr(4'he, 2'b00, 6'b011000, 4'hf, 4'd0, 99, "dp.orr_pc");
      run_instr(4'he, 2'b00, 6'b001110, 4'd4, 4'd0, 99, "dp.othercmd");
   endtask

   task automatic test_mem;
      run_instr(4'he, 2'b01, 6'b011001, 4'd5, 4'd0, 99, "mem.ldr");
      run_instr(4'he, 2'b01, 6'b011000, 4'd5, 4'd0, 99, "mem.str");
      run_instr(4'he, 2'b01, 6'b011001, 4'hf, 4'd0, 99, "mem.ldr_pc");
   endtask

   task automatic test_flags_branch;
      run_instr(4'he, 2'b00, 6'b000101, 4'd1, 4'b0100, 99, "br.subs");
      run_instr(4'h0, 2'b10, 6'd0, 4'd0, 4'd0, 99, "br.beq_taken");
      run_instr(4'h1, 2'b10, 6'd0, 4'd0, 4'd0, 99, "br.bne_nottaken");
      run_instr(4'he, 2'b11, 6'd0, 4'd0, 4'd0, 99, "br.undef");
      run_instr(4'hf, 2'b10, 6'd0, 4'd0, 4'd0, 99, "br.never");
   endtask

   task automatic test_cond_fail;
      run_instr(4'he, 2'b00, 6'b000101, 4'd1, 4'b0000, 99, "cond.subs_clear");
      run_instr(4'h0, 2'b00, 6'b001000, 4'd1, 4'd0, 99, "cond.addeq_fail");
      run_instr(4'h0, 2'b01, 6'b011000, 4'd1, 4'd0, 99, "cond.streq_fail");
   endtask

   task automatic test_cmp;
      run_instr(4'he, 2'b00, 6'b010101, 4'd0, 4'b1000, 99, "cmp.cmp");
      run_instr(4'h4, 2'b10, 6'd0, 4'd0, 4'd0, 99, "cmp.bmi");
      run_instr(4'he, 2'b00, 6'b110101, 4'd0, 4'b0101, 99, "cmp.cmpi");
      run_instr(4'h6, 2'b10, 6'd0, 4'd0, 4'd0, 99, "cmp.bvs");
   endtask

   task automatic test_random;
      logic [3:0] cmds[6];
      logic [5:0] fn;
      logic [3:0] rd;
      cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b0111};
      for (int i = 0; i < 200; i++) begin
         fn = 6'($urandom);
         if ($urandom_range(0, 3) != 0) fn[4:1] = cmds[$urandom_range(0, 5)];
         rd = ($urandom_range(0, 4) == 0) ? 4'hf : 4'($urandom);
         run_instr(4'($urandom), 2'($urandom), fn, rd, 4'($urandom), 99, "rand");
      end
   endtask

   initial begin
      test_reset();
      test_dp();
      test_mem();
      test_flags_branch();
      test_cond_fail();
      test_cmp();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
